// File: rtl/csel_add_seq_ctrl_pkg.sv
// Shared types for the word-serial carry-select adder sequencer.
// State encoding and index-width helper used by the controller.
package csel_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csel_add_seq_ctrl_if.sv
// Request/response handshake bundle for the adder sequencer.
// The master drives operands and accepts results; the slave is the sequencer.
interface csel_add_seq_ctrl_if #(
    parameter int width = 20,
    parameter int WORDS = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WORDS*width-1:0]   in_a;
    logic [WORDS*width-1:0]   in_b;
    logic                     in_cin;
    logic                     out_valid;
    logic                     out_ready;
    logic [WORDS*width-1:0]   out_sum;
    logic                     out_cout;
    logic                     busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/csel_add_seq_ctrl_adder.sv
// One-word carry-select adder: low half ripples, high half is precomputed
// for both carries and picked by the low-half carry out.
module C_Sel_A_20bit #(
    parameter int width = 20
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             cin,
    output logic [width-1:0] S,
    output logic             cout
);
    localparam int LO = width / 2;
    localparam int HI = width - LO;

    logic [LO:0] w_lo;
    logic [HI:0] w_hi0;
    logic [HI:0] w_hi1;

    assign w_lo  = {1'b0, A[LO-1:0]} + {1'b0, B[LO-1:0]}
                 + {{LO{1'b0}}, cin};
    assign w_hi0 = {1'b0, A[width-1:LO]} + {1'b0, B[width-1:LO]};
    assign w_hi1 = w_hi0 + {{HI{1'b0}}, 1'b1};

    assign {cout, S} = w_lo[LO] ? {w_hi1, w_lo[LO-1:0]}
                                : {w_hi0, w_lo[LO-1:0]};
endmodule

// File: rtl/csel_add_seq_ctrl.sv
// Drives a single word adder over WORDS cycles to form a wide sum,
// chaining each word's carry out into the next word's carry in.
module csel_add_seq_ctrl
    import csel_seq_pkg::*;
#(
    parameter int width = 20,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csel_add_seq_ctrl_if.slave   bus
);
    localparam int OPW   = WORDS * width;
    localparam int CNT_W = cnt_w(WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_idx;
    logic             r_carry;
    logic [OPW-1:0]   r_a;
    logic [OPW-1:0]   r_b;
    logic [OPW-1:0]   r_sum;
    logic             r_cout;
    logic             r_valid;

    logic [width-1:0] w_a;
    logic [width-1:0] w_b;
    logic [width-1:0] w_s;
    logic             w_cout;

    assign w_a = r_a[int'(r_idx)*width +: width];
    assign w_b = r_b[int'(r_idx)*width +: width];

    C_Sel_A_20bit #(.width(width)) u_add (
        .A    (w_a),
        .B    (w_b),
        .cin  (r_carry),
        .S    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_carry <= bus.in_cin;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[int'(r_idx)*width +: width] <= w_s;
                    r_carry <= w_cout;
                    if (r_idx == LAST) begin
                        r_idx   <= '0;
                        r_cout  <= w_cout;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // new requests wait until the cycle after hand-off
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
endmodule
